// File: rtl/traffic_manual_input.sv
// Manual-control front end for the traffic light controller: synchronises and
// debounces the mode/step buttons, emits one-cycle press strobes, and tracks
// the manual override mode and the selected light with an idle auto-release.
module traffic_manual_input #(
  parameter logic [15:0] DEBOUNCE_CYCLES = 16'd50000,
  parameter logic [31:0] TIMEOUT_CYCLES  = 32'd0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_mode_raw,
  input  logic       btn_step_raw,
  output logic       manual_override,
  output logic [1:0] manual_state,
  output logic       mode_pulse,
  output logic       step_pulse
);

  typedef enum logic {
    AUTO,
    MANUAL
  } mode_t;

  typedef enum logic [1:0] {
    LIGHT_RED    = 2'b00,
    LIGHT_YELLOW = 2'b01,
    LIGHT_GREEN  = 2'b10
  } light_t;

  // Index 0 = mode button, index 1 = step button.
  logic [1:0]  raw;
  logic [1:0]  sync_a;
  logic [1:0]  sync_b;
  logic [1:0]  sync_vld;
  logic [1:0]  level;
  logic [1:0]  level_q;
  logic [1:0]  armed;
  logic [1:0]  pulse;
  logic [1:0]  differ;
  logic [15:0] cnt [2];

  mode_t       fsm;
  light_t      light;
  logic [31:0] idle;

  assign raw          = {btn_step_raw, btn_mode_raw};
  assign mode_pulse   = pulse[0];
  assign step_pulse   = pulse[1];
  assign manual_state = light;

  // Debounce comparison. Until a button has been seen stably released after
  // reset it is treated as pressed, so a button held through reset must be
  // released and debounced low (arming) before a press can be accepted.
  always_comb begin
    differ = '0;
    for (int unsigned i = 0; i < 2; i++) begin
      differ[i] = sync_vld[1] && (sync_b[i] != (armed[i] ? level[i] : 1'b1));
    end
  end

  // Per-button synchroniser, debounce counter, arming and press strobe.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_a   <= '0;
      sync_b   <= '0;
      sync_vld <= '0;
      level    <= '0;
      level_q  <= '0;
      armed    <= '0;
      pulse    <= '0;
      for (int unsigned i = 0; i < 2; i++) begin
        cnt[i] <= '0;
      end
    end else begin
      sync_a   <= raw;
      sync_b   <= sync_a;
      sync_vld <= {sync_vld[0], 1'b1};
      level_q  <= level;
      pulse    <= level & ~level_q;
      for (int unsigned i = 0; i < 2; i++) begin
        if (!differ[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == DEBOUNCE_CYCLES - 16'd1) begin
          cnt[i] <= '0;
          if (armed[i]) begin
            level[i] <= ~level[i];
          end else begin
            armed[i] <= 1'b1;
          end
        end else begin
          cnt[i] <= cnt[i] + 16'd1;
        end
      end
    end
  end

  // Override FSM with registered outputs and idle auto-release.
  always_ff @(posedge clk) begin
    if (reset) begin
      fsm             <= AUTO;
      manual_override <= 1'b0;
      light           <= LIGHT_RED;
      idle            <= '0;
    end else begin
      case (fsm)
        AUTO: begin
          idle <= '0;
          if (mode_pulse) begin
            fsm             <= MANUAL;
            manual_override <= 1'b1;
            light           <= LIGHT_RED;
          end
        end
        MANUAL: begin
          if (mode_pulse) begin
            fsm             <= AUTO;
            manual_override <= 1'b0;
            light           <= LIGHT_RED;
            idle            <= '0;
          end else if (step_pulse) begin
            idle <= '0;
            case (light)
              LIGHT_RED:    light <= LIGHT_YELLOW;
              LIGHT_YELLOW: light <= LIGHT_GREEN;
              default:      light <= LIGHT_RED;
            endcase
          end else if ((TIMEOUT_CYCLES != 32'd0) &&
                       (idle == TIMEOUT_CYCLES - 32'd1)) begin
            fsm             <= AUTO;
            manual_override <= 1'b0;
            light           <= LIGHT_RED;
            idle            <= '0;
          end else if (idle != '1) begin
            idle <= idle + 32'd1;
          end
        end
        default: begin
          fsm             <= AUTO;
          manual_override <= 1'b0;
          light           <= LIGHT_RED;
          idle            <= '0;
        end
      endcase
    end
  end

endmodule
